// File: rtl/rv_mem_arb.sv
// Shares one single-ported 64-bit memory between instruction fetch (IF) and data memory (DM).
// One transaction is outstanding at a time. DM wins by default, a starvation counter forces IF progress, and a watchdog aborts hung accesses.
//
// Handshake: a requester holds *_req_i until it sees *_gnt_o, which is combinational in the same IDLE cycle.
// The transaction then completes with exactly one *_rvalid_o pulse, on mem_rvalid_i or on the watchdog abort.
module rv_mem_arb #(
   parameter int ADDR_W     = 64,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [63:0]       dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [63:0]       dm_rdata_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [63:0]       mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [63:0]       mem_rdata_i,
   output logic              o_dbg_state,
   output logic [3:0]        o_dbg_starve_cnt
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

   logic [0:0] r_state;
   logic       r_owner;
   logic       r_sel_hi;
   logic       r_we;
   logic [3:0] r_starve_cnt;
   logic [7:0] r_wd_cnt;

   logic w_idle;
   logic w_wait;
   logic w_if_win;
   logic w_dm_win;
   logic w_resp;
   logic w_tout;
   logic w_done;

   assign w_idle = (r_state == S_IDLE);
   assign w_wait = (r_state == S_WAIT);

   // IF beats a competing DM request only once it has lost STARVE_MAX times in a row.
   assign w_if_win = w_idle & if_req_i & (~dm_req_i | (r_starve_cnt == STARVE_LIM));
   assign w_dm_win = w_idle & dm_req_i & ~w_if_win;

   // A real response in the timeout cycle takes priority over the abort.
   assign w_resp = w_wait & mem_rvalid_i;
   assign w_tout = w_wait & ~mem_rvalid_i & (r_wd_cnt == WD_LAST);
   assign w_done = w_resp | w_tout;

   always_comb begin
      if_gnt_o    = w_if_win;
      dm_gnt_o    = w_dm_win;
      mem_req_o   = w_if_win | w_dm_win;
      mem_we_o    = w_dm_win & dm_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_if_win) begin
         mem_addr_o = if_addr_i;
      end else if (w_dm_win) begin
         mem_addr_o  = dm_addr_i;
         mem_wdata_o = dm_wdata_i;
      end
   end

   always_comb begin
      if_rvalid_o = w_done & ~r_owner;
      dm_rvalid_o = w_done & r_owner;
      err_o       = w_tout;
      if_rdata_o  = '0;
      dm_rdata_o  = '0;
      if (w_resp && !r_owner) begin
         if_rdata_o = r_sel_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      end
      // Write acknowledges carry no data.
      if (w_resp && r_owner && !r_we) begin
         dm_rdata_o = mem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_sel_hi <= 1'b0;
         r_we     <= 1'b0;
         r_wd_cnt <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_if_win || w_dm_win) begin
                  r_state  <= S_WAIT;
                  r_owner  <= w_dm_win;
                  r_wd_cnt <= 8'd0;
                  if (w_if_win) r_sel_hi <= if_addr_i[2];
                  if (w_dm_win) r_we <= dm_we_i;
               end
            end
            S_WAIT: begin
               if (w_done) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_starve_cnt <= 4'd0;
      end else if (w_if_win) begin
         r_starve_cnt <= 4'd0;
      end else if (w_dm_win && if_req_i && (r_starve_cnt < STARVE_LIM)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   assign o_dbg_state      = r_state[0];
   assign o_dbg_starve_cnt = r_starve_cnt;

endmodule
